// File: rtl/bubble_pkg.sv
// bubble_pkg: shared encodings for the bubble data output path.
//   - ACCTYPE encodings, the "no cycle" marker, tick phase constants,
//     FSM state type and a 2-bit popcount helper.
package bubble_pkg;

  localparam logic [2:0]  ACC_RST  = 3'b000;
  localparam logic [2:0]  ACC_STBY = 3'b001;
  localparam logic [2:0]  ACC_IDLE = 3'b100;
  localparam logic [2:0]  ACC_BOOT = 3'b110;
  localparam logic [2:0]  ACC_USER = 3'b111;

  localparam logic [12:0] NO_CYCLE = 13'h1FFF;

  localparam logic [1:0]  TICK_FETCH   = 2'd0;
  localparam logic [1:0]  TICK_DRIVE   = 2'd2;
  localparam logic [1:0]  TICK_RELEASE = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_ARMED,
    ST_DRIVE
  } bdo_state_e;

  function automatic logic [1:0] popcnt2(input logic [1:0] v);
    return {1'b0, v[1]} + {1'b0, v[0]};
  endfunction

endpackage

// File: rtl/bdo_event_detect.sv
// bdo_event_detect: registers {cycle, ticks} every clock and flags a
// one-clock event whenever the new sample differs from the stored one.
//   clk, rst_n  : clock, synchronous active-low reset
//   cyc_i/ticks_i : raw cycle number / tick phase from the timing generator
//   evt_o       : one-clock pulse, aligned with the new registered sample
//   cyc_o/ticks_o : registered cycle number / tick phase
module bdo_event_detect
  import bubble_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] cyc_i,
  input  logic [1:0]  ticks_i,
  output logic        evt_o,
  output logic [12:0] cyc_o,
  output logic [1:0]  ticks_o
);

  logic [12:0] cyc_q, cyc_d;
  logic [1:0]  ticks_q, ticks_d;
  logic        evt_q, evt_d;

  always_comb begin
    cyc_d   = cyc_i;
    ticks_d = ticks_i;
    evt_d   = ({cyc_i, ticks_i} != {cyc_q, ticks_q});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_q   <= NO_CYCLE;
      ticks_q <= 2'd0;
      evt_q   <= 1'b0;
    end else begin
      cyc_q   <= cyc_d;
      ticks_q <= ticks_d;
      evt_q   <= evt_d;
    end
  end

  assign evt_o   = evt_q;
  assign cyc_o   = cyc_q;
  assign ticks_o = ticks_q;

endmodule

// File: rtl/bubble_data_out.sv
// bubble_data_out: fetches the bit pair for each output bubble cycle from
// the buffer RAM and drives the two active-low data lines at tick 2,
// releasing them at tick 3.
//   MCLK, nRST     : clock, synchronous active-low reset
//   ACCTYPE        : access type (BOOT/USER are transfer types)
//   BOUTCYCLENUM   : output cycle number, 13'h1FFF = none
//   BOUTTICKS      : phase within bubble cycle
//   BUFRDEN/ADDR   : one-clock read strobe and address to buffer RAM
//   BUFRDDATA      : read data, valid one clock after the strobe
//   nDOUT0/1       : bubble data lines, active low
//   UNDERRUN       : sticky, drive phase reached without fetched data
//   ONECOUNT       : (only with BDO_ONECOUNT_EN) saturating count of bits
//                    driven low, cleared on entry to BOOT/USER
module bubble_data_out
  import bubble_pkg::*;
(
  input  logic        MCLK,
  input  logic        nRST,
  input  logic [2:0]  ACCTYPE,
  input  logic [12:0] BOUTCYCLENUM,
  input  logic [1:0]  BOUTTICKS,
  output logic        BUFRDEN,
  output logic [12:0] BUFRDADDR,
  input  logic [1:0]  BUFRDDATA,
  output logic        nDOUT0,
  output logic        nDOUT1,
`ifdef BDO_ONECOUNT_EN
  output logic [15:0] ONECOUNT,
`endif
  output logic        UNDERRUN
);

  logic        evt;
  logic [12:0] ev_cyc;
  logic [1:0]  ev_ticks;

  bdo_event_detect u_evt (
    .clk     (MCLK),
    .rst_n   (nRST),
    .cyc_i   (BOUTCYCLENUM),
    .ticks_i (BOUTTICKS),
    .evt_o   (evt),
    .cyc_o   (ev_cyc),
    .ticks_o (ev_ticks)
  );

  // Raw inputs so an abort takes effect on the very next clock.
  logic valid;
  assign valid = ACCTYPE[1] & (BOUTCYCLENUM != NO_CYCLE);

  logic unused_ok;
  assign unused_ok = &{1'b0, ACCTYPE[2], ACCTYPE[0]};

  bdo_state_e  state_q, state_d;
  logic        bufrden_q, bufrden_d;
  logic [12:0] addr_q, addr_d;
  logic [1:0]  shadow_q, shadow_d;
  logic        shadow_ok_q, shadow_ok_d;
  logic [1:0]  ndout_q, ndout_d;
  logic        underrun_q, underrun_d;

  always_comb begin
    state_d     = state_q;
    bufrden_d   = 1'b0;
    addr_d      = addr_q;
    shadow_d    = shadow_q;
    shadow_ok_d = shadow_ok_q;
    ndout_d     = ndout_q;
    underrun_d  = underrun_q;

    if (!valid) begin
      state_d     = ST_IDLE;
      ndout_d     = 2'b11;
      shadow_ok_d = 1'b0;
    end else if (evt && ev_ticks == TICK_FETCH) begin
      // New cycle overrides whatever is in progress. If a strobe is out
      // this clock, defer the new one so strobes never touch.
      state_d     = ST_FETCH;
      addr_d      = ev_cyc;
      ndout_d     = 2'b11;
      shadow_ok_d = 1'b0;
      bufrden_d   = !bufrden_q;
    end else if (evt && ev_ticks == TICK_DRIVE && state_q != ST_ARMED) begin
      // Drive phase arrived before data was ready: the cycle is lost.
      underrun_d  = 1'b1;
      state_d     = ST_IDLE;
      ndout_d     = 2'b11;
      shadow_ok_d = 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          // bufrden_q low here means the strobe was deferred.
          if (bufrden_q) state_d   = ST_LATCH;
          else           bufrden_d = 1'b1;
        end
        ST_LATCH: begin
          shadow_d    = BUFRDDATA;
          shadow_ok_d = 1'b1;
          state_d     = ST_ARMED;
        end
        ST_ARMED: begin
          if (evt && ev_ticks == TICK_DRIVE && shadow_ok_q) begin
            state_d = ST_DRIVE;
            ndout_d = ~shadow_q;
          end
        end
        ST_DRIVE: begin
          if (evt && ev_ticks == TICK_RELEASE) begin
            state_d     = ST_IDLE;
            ndout_d     = 2'b11;
            shadow_ok_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge MCLK) begin
    if (!nRST) begin
      state_q     <= ST_IDLE;
      bufrden_q   <= 1'b0;
      addr_q      <= 13'd0;
      shadow_q    <= 2'b00;
      shadow_ok_q <= 1'b0;
      ndout_q     <= 2'b11;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bufrden_q   <= bufrden_d;
      addr_q      <= addr_d;
      shadow_q    <= shadow_d;
      shadow_ok_q <= shadow_ok_d;
      ndout_q     <= ndout_d;
      underrun_q  <= underrun_d;
    end
  end

  assign BUFRDEN   = bufrden_q;
  assign BUFRDADDR = addr_q;
  assign nDOUT0    = ndout_q[0];
  assign nDOUT1    = ndout_q[1];
  assign UNDERRUN  = underrun_q;

`ifdef BDO_ONECOUNT_EN
  logic [2:0]  acc_q, acc_d;
  logic [15:0] onecnt_q, onecnt_d;
  logic [16:0] onesum;
  logic        drive_entry;

  assign drive_entry = (state_q == ST_ARMED) && (state_d == ST_DRIVE);
  assign onesum      = {1'b0, onecnt_q} + {15'd0, popcnt2(shadow_q)};

  always_comb begin
    acc_d    = ACCTYPE;
    onecnt_d = onecnt_q;
    if ((ACCTYPE == ACC_BOOT || ACCTYPE == ACC_USER) && ACCTYPE != acc_q)
      onecnt_d = 16'd0;
    else if (drive_entry)
      onecnt_d = onesum[16] ? 16'hFFFF : onesum[15:0];
  end

  always_ff @(posedge MCLK) begin
    if (!nRST) begin
      acc_q    <= ACC_RST;
      onecnt_q <= 16'd0;
    end else begin
      acc_q    <= acc_d;
      onecnt_q <= onecnt_d;
    end
  end

  assign ONECOUNT = onecnt_q;
`endif

endmodule

// File: tb/tb_bubble_data_out.sv
// Directed bench for bubble_data_out. Models the buffer RAM as a one-clock
// registered read and counts strobes on the side.
module tb_bubble_data_out;
  import bubble_pkg::*;

  logic        MCLK = 1'b0;
  logic        nRST = 1'b0;
  logic [2:0]  ACCTYPE = ACC_RST;
  logic [12:0] BOUTCYCLENUM = NO_CYCLE;
  logic [1:0]  BOUTTICKS = 2'd0;
  logic        BUFRDEN;
  logic [12:0] BUFRDADDR;
  logic [1:0]  BUFRDDATA = 2'b00;
  logic        nDOUT0, nDOUT1, UNDERRUN;
`ifdef BDO_ONECOUNT_EN
  logic [15:0] ONECOUNT;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [1:0]  ram_val = 2'b00;
  int          rd_cnt = 0;
  int          b2b = 0;
  int          rd_base;
  logic [12:0] last_addr = 13'd0;
  logic        prev_en = 1'b0;

  bubble_data_out dut (
    .MCLK         (MCLK),
    .nRST         (nRST),
    .ACCTYPE      (ACCTYPE),
    .BOUTCYCLENUM (BOUTCYCLENUM),
    .BOUTTICKS    (BOUTTICKS),
    .BUFRDEN      (BUFRDEN),
    .BUFRDADDR    (BUFRDADDR),
    .BUFRDDATA    (BUFRDDATA),
    .nDOUT0       (nDOUT0),
    .nDOUT1       (nDOUT1),
`ifdef BDO_ONECOUNT_EN
    .ONECOUNT     (ONECOUNT),
`endif
    .UNDERRUN     (UNDERRUN)
  );

  always #5 MCLK = ~MCLK;

  // Buffer RAM: data appears one clock after the strobe, zeros otherwise.
  always @(posedge MCLK) begin
    BUFRDDATA <= BUFRDEN ? ram_val : 2'b00;
    if (BUFRDEN) begin
      rd_cnt    <= rd_cnt + 1;
      last_addr <= BUFRDADDR;
    end
    if (BUFRDEN && prev_en) b2b <= b2b + 1;
    prev_en <= BUFRDEN;
  end

  task automatic step(input int n);
    repeat (n) @(posedge MCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic run_cycle(input string tag, input logic [12:0] cyc, input logic [1:0] data);
    logic [1:0] exp_lines;
    exp_lines    = ~data;
    ram_val      = data;
    BOUTCYCLENUM = cyc;
    BOUTTICKS    = 2'd0;
    step(4);
    BOUTTICKS = 2'd2;
    step(2);
    chk({tag, " drive"}, {30'd0, nDOUT1, nDOUT0}, {30'd0, exp_lines});
    BOUTTICKS = 2'd3;
    step(2);
    chk({tag, " release"}, {30'd0, nDOUT1, nDOUT0}, 32'd3);
  endtask

  initial begin
    // Reset state
    step(3);
    chk("rst ndout0", nDOUT0, 1);
    chk("rst ndout1", nDOUT1, 1);
    chk("rst en", BUFRDEN, 0);
    chk("rst addr", BUFRDADDR, 0);
    chk("rst underrun", UNDERRUN, 0);
    nRST = 1'b1;
    step(2);

    // USER, cycle 5, data 10
    ACCTYPE = ACC_USER;
    rd_base = rd_cnt;
    ram_val = 2'b10;
    BOUTCYCLENUM = 13'd5;
    BOUTTICKS = 2'd0;
    step(1);
    chk("t1 en early", BUFRDEN, 0);
    step(1);
    chk("t1 en", BUFRDEN, 1);
    chk("t1 addr", BUFRDADDR, 5);
    step(1);
    chk("t1 en drop", BUFRDEN, 0);
    step(2);
    BOUTTICKS = 2'd2;
    step(1);
    chk("t1 pre-drive", {nDOUT1, nDOUT0}, 2'b11);
    step(1);
    chk("t1 ndout1", nDOUT1, 0);
    chk("t1 ndout0", nDOUT0, 1);
    step(2);
    BOUTTICKS = 2'd3;
    step(1);
    chk("t1 hold", nDOUT1, 0);
    step(1);
    chk("t1 released", {nDOUT1, nDOUT0}, 2'b11);
    chk("t1 one read", rd_cnt - rd_base, 1);

    // BOOT wrap 4105 -> 0
    ACCTYPE = ACC_BOOT;
    rd_base = rd_cnt;
    run_cycle("t2 4105", 13'd4105, 2'b11);
    chk("t2 addr 4105", last_addr, 4105);
    run_cycle("t2 0", 13'd0, 2'b11);
    chk("t2 addr 0", last_addr, 0);
    chk("t2 reads", rd_cnt - rd_base, 2);
    chk("t2 no underrun", UNDERRUN, 0);

    // Ticks 0 -> 2 before data latched
    ACCTYPE = ACC_USER;
    ram_val = 2'b11;
    BOUTCYCLENUM = 13'd7;
    BOUTTICKS = 2'd0;
    step(1);
    BOUTTICKS = 2'd2;
    step(3);
    chk("t3 lines high", {nDOUT1, nDOUT0}, 2'b11);
    chk("t3 underrun", UNDERRUN, 1);
    run_cycle("t3 good", 13'd8, 2'b01);
    chk("t3 underrun sticky", UNDERRUN, 1);

    // Abort while driving
    ram_val = 2'b11;
    BOUTCYCLENUM = 13'd9;
    BOUTTICKS = 2'd0;
    step(4);
    BOUTTICKS = 2'd2;
    step(2);
    chk("t4 driving", {nDOUT1, nDOUT0}, 2'b00);
    rd_base = rd_cnt;
    ACCTYPE = ACC_RST;
    step(1);
    chk("t4 abort lines", {nDOUT1, nDOUT0}, 2'b11);
    BOUTCYCLENUM = 13'd10;
    BOUTTICKS = 2'd0;
    step(4);
    chk("t4 no reads", rd_cnt - rd_base, 0);
    chk("t4 en low", BUFRDEN, 0);

    // Reset mid-drive, then a fresh cycle 0
    ACCTYPE = ACC_USER;
    BOUTCYCLENUM = 13'd11;
    BOUTTICKS = 2'd0;
    step(4);
    BOUTTICKS = 2'd2;
    step(2);
    chk("t5 driving", {nDOUT1, nDOUT0}, 2'b00);
    nRST = 1'b0;
    step(1);
    chk("t5 rst lines", {nDOUT1, nDOUT0}, 2'b11);
    chk("t5 rst en", BUFRDEN, 0);
    chk("t5 rst addr", BUFRDADDR, 0);
    chk("t5 rst underrun", UNDERRUN, 0);
    nRST = 1'b1;
    rd_base = rd_cnt;
    run_cycle("t5 fresh", 13'd0, 2'b01);
    chk("t5 reads", rd_cnt - rd_base, 1);
    chk("t5 addr", last_addr, 0);
    chk("t5 underrun", UNDERRUN, 0);

`ifdef BDO_ONECOUNT_EN
    ACCTYPE = ACC_IDLE;
    step(2);
    ACCTYPE = ACC_USER;
    step(2);
    chk("oc cleared", ONECOUNT, 0);
    run_cycle("oc 11", 13'd1, 2'b11);
    run_cycle("oc 01", 13'd2, 2'b01);
    run_cycle("oc 00", 13'd3, 2'b00);
    chk("oc count", ONECOUNT, 3);
    ACCTYPE = ACC_IDLE;
    step(2);
    ACCTYPE = ACC_USER;
    step(2);
    chk("oc reenter", ONECOUNT, 0);
`endif

    chk("no back-to-back strobes", b2b, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
